// File: rtl/regfile_wb_sched_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the register-file write-back scheduler.
//   XLEN       : integer data width
//   REG_ADDR_W : architectural register index width
//   NUM_REGS   : number of architectural registers (x0..x31)
//   REG_ZERO   : index of the hardwired-zero register
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]       xword_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

  // True for any register that actually stores state (everything but x0).
  function automatic logic is_arch_reg(input reg_idx_t idx);
    return (idx != REG_ZERO);
  endfunction

endpackage

// File: rtl/regfile_wb_sched_if.sv
// -----------------------------------------------------------------------------
// regfile_wb_sched_if
// Bundles the write-back request bus, the decode issue bus and the register
// file write port of the write-back scheduler.
//   master : execute/memory requesters + decode (drive requests and issue)
//   slave  : the scheduler (drives grants, stall, rf write port, busy_vec)
// Parameter NUM_REQ : number of write-back requesters.
// -----------------------------------------------------------------------------
interface regfile_wb_sched_if #(
  parameter int NUM_REQ = 3
);
  import regfile_pkg::*;

  // Write-back requesters (slice i belongs to requester i)
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*REG_ADDR_W-1:0] req_rd;
  logic [NUM_REQ*XLEN-1:0]       req_data;
  logic [NUM_REQ-1:0]            req_ready;

  // Decode issue side
  logic     issue_valid;
  reg_idx_t issue_rd;
  logic     issue_rd_en;
  reg_idx_t issue_rs1;
  logic     issue_rs1_en;
  reg_idx_t issue_rs2;
  logic     issue_rs2_en;
  logic     issue_stall;

  // Register file write port and scoreboard view
  reg_idx_t            rf_rd;
  logic                rf_rd_en;
  xword_t              rf_data_in;
  logic [NUM_REGS-1:0] busy_vec;

  modport master (
    output req_valid, req_rd, req_data,
    output issue_valid, issue_rd, issue_rd_en,
    output issue_rs1, issue_rs1_en, issue_rs2, issue_rs2_en,
    input  req_ready, issue_stall,
    input  rf_rd, rf_rd_en, rf_data_in, busy_vec
  );

  modport slave (
    input  req_valid, req_rd, req_data,
    input  issue_valid, issue_rd, issue_rd_en,
    input  issue_rs1, issue_rs1_en, issue_rs2, issue_rs2_en,
    output req_ready, issue_stall,
    output rf_rd, rf_rd_en, rf_data_in, busy_vec
  );

endinterface

// File: rtl/regfile_wb_sched_arb.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter
// Single-grant arbiter for the write-back requesters. Grant is combinational.
// Default build: round-robin starting at a pointer that advances to
// (winner + 1) mod NUM_REQ on every grant.
// Macro WB_FIXED_PRIO_EN: fixed priority, lowest index wins, no pointer.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_req        : request vector
//   o_gnt        : one-hot grant
//   o_gnt_idx    : index of the granted requester (0 when none)
//   o_gnt_valid  : a grant is issued this cycle
// -----------------------------------------------------------------------------
module wb_rr_arbiter #(
  parameter  int NUM_REQ = 3,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_gnt_idx,
  output logic               o_gnt_valid
);

`ifdef WB_FIXED_PRIO_EN

  // Fixed priority: the first requester found from index 0 upward wins.
  always_comb begin
    o_gnt       = '0;
    o_gnt_idx   = '0;
    o_gnt_valid = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!o_gnt_valid && i_req[j]) begin
        o_gnt[j]    = 1'b1;
        o_gnt_idx   = IDX_W'(j);
        o_gnt_valid = 1'b1;
      end else begin
      end
    end
  end

`else

  logic [IDX_W-1:0] r_ptr;

  // Round-robin search in two passes: first indices >= pointer, then wrap
  // around to the low indices.
  always_comb begin
    o_gnt       = '0;
    o_gnt_idx   = '0;
    o_gnt_valid = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!o_gnt_valid && i_req[j] && (j >= int'(r_ptr))) begin
        o_gnt[j]    = 1'b1;
        o_gnt_idx   = IDX_W'(j);
        o_gnt_valid = 1'b1;
      end else begin
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!o_gnt_valid && i_req[j]) begin
        o_gnt[j]    = 1'b1;
        o_gnt_idx   = IDX_W'(j);
        o_gnt_valid = 1'b1;
      end else begin
      end
    end
  end

  // Pointer moves past the winner, and only when something was granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (o_gnt_valid) begin
      r_ptr <= (o_gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : o_gnt_idx + IDX_W'(1);
    end else begin
      r_ptr <= r_ptr;
    end
  end

`endif

endmodule

// File: rtl/regfile_wb_sched.sv
// -----------------------------------------------------------------------------
// regfile_wb_sched
// Write-back scheduler and scoreboard for the 32x32 integer register file.
// Arbitrates NUM_REQ write-back requesters onto the single register-file write
// port (one-cycle registered latency) and keeps a busy bit per architectural
// register so decode stalls on RAW/WAW hazards until the write commits.
// Optional macro WB_FIXED_PRIO_EN selects fixed-priority arbitration.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset, clears all state
//   wb     : regfile_wb_sched_if.slave (requests, issue, rf port, busy_vec)
// -----------------------------------------------------------------------------
module regfile_wb_sched
  import regfile_pkg::*;
#(
  parameter  int NUM_REQ = 3,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  regfile_wb_sched_if.slave  wb
);

  logic [NUM_REQ-1:0]  w_gnt;
  logic [IDX_W-1:0]    w_gnt_idx;
  logic                w_gnt_valid;
  reg_idx_t            w_win_rd;
  xword_t              w_win_data;
  logic                w_stall;
  logic                w_set;
  logic [NUM_REGS-1:0] w_busy_nxt;

  reg_idx_t            r_rf_rd;
  logic                r_rf_rd_en;
  xword_t              r_rf_data;
  logic [NUM_REGS-1:0] r_busy;

  wb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req       (wb.req_valid),
    .o_gnt       (w_gnt),
    .o_gnt_idx   (w_gnt_idx),
    .o_gnt_valid (w_gnt_valid)
  );

  // Select the winner's destination and data from the packed request buses.
  always_comb begin
    w_win_rd   = REG_ZERO;
    w_win_data = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_gnt[j]) begin
        w_win_rd   = wb.req_rd[j*REG_ADDR_W +: REG_ADDR_W];
        w_win_data = wb.req_data[j*XLEN +: XLEN];
      end else begin
      end
    end
  end

  // Commit register: load on grant; writes to x0 are accepted but not enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_rd    <= REG_ZERO;
      r_rf_rd_en <= 1'b0;
      r_rf_data  <= '0;
    end else if (w_gnt_valid) begin
      r_rf_rd    <= w_win_rd;
      r_rf_rd_en <= is_arch_reg(w_win_rd);
      r_rf_data  <= w_win_data;
    end else begin
      r_rf_rd    <= r_rf_rd;
      r_rf_rd_en <= 1'b0;
      r_rf_data  <= r_rf_data;
    end
  end

  // Hazard check against the current scoreboard; no bypass from the commit stage.
  always_comb begin
    w_stall = wb.issue_valid & ((wb.issue_rs1_en & r_busy[wb.issue_rs1]) |
                                (wb.issue_rs2_en & r_busy[wb.issue_rs2]) |
                                (wb.issue_rd_en  & r_busy[wb.issue_rd]));
    w_set   = wb.issue_valid & ~w_stall & wb.issue_rd_en & is_arch_reg(wb.issue_rd);
  end

  // Scoreboard next state: clear on commit, then set on issue so set wins a
  // same-index collision (the new instruction owns the register).
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_rf_rd_en) begin
      w_busy_nxt[r_rf_rd] = 1'b0;
    end else begin
    end
    if (w_set) begin
      w_busy_nxt[wb.issue_rd] = 1'b1;
    end else begin
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Scoreboard state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign wb.req_ready   = w_gnt;
  assign wb.issue_stall = w_stall;
  assign wb.rf_rd       = r_rf_rd;
  assign wb.rf_rd_en    = r_rf_rd_en;
  assign wb.rf_data_in  = r_rf_data;
  assign wb.busy_vec    = r_busy;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_sched
// Directed, table-driven bench for regfile_wb_sched (NUM_REQ = 3), plus
// hand-written sequences for reset during a write and arbitration order.
// -----------------------------------------------------------------------------
module tb_regfile_wb_sched;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  regfile_wb_sched_if #(.NUM_REQ(3)) bus();

  regfile_wb_sched #(.NUM_REQ(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  valid;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        iv;
    logic [4:0]  ird;
    logic        ird_en;
    logic [4:0]  rs1;
    logic        rs1_en;
    logic [4:0]  rs2;
    logic        rs2_en;
    logic [2:0]  exp_ready;
    logic        exp_stall;
    logic        exp_en;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    logic [31:0] exp_busy;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(
    input logic [2:0] valid, input logic [4:0] rd, input logic [31:0] data,
    input logic iv, input logic [4:0] ird, input logic ird_en,
    input logic [4:0] rs1, input logic rs1_en, input logic [4:0] rs2, input logic rs2_en,
    input logic [2:0] exp_ready, input logic exp_stall, input logic exp_en,
    input logic [4:0] exp_rd, input logic [31:0] exp_data, input logic [31:0] exp_busy);
    vec_t v;
    v.valid = valid; v.rd = rd; v.data = data;
    v.iv = iv; v.ird = ird; v.ird_en = ird_en;
    v.rs1 = rs1; v.rs1_en = rs1_en; v.rs2 = rs2; v.rs2_en = rs2_en;
    v.exp_ready = exp_ready; v.exp_stall = exp_stall; v.exp_en = exp_en;
    v.exp_rd = exp_rd; v.exp_data = exp_data; v.exp_busy = exp_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid    = 3'b000;
    bus.req_rd       = 15'd0;
    bus.req_data     = 96'd0;
    bus.issue_valid  = 1'b0;
    bus.issue_rd     = 5'd0;
    bus.issue_rd_en  = 1'b0;
    bus.issue_rs1    = 5'd0;
    bus.issue_rs1_en = 1'b0;
    bus.issue_rs2    = 5'd0;
    bus.issue_rs2_en = 1'b0;
  endtask

  initial begin
    int exp_idx;
    n_total = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    idle_inputs();

    // Each vector holds for one cycle; only one requester is valid per vector.
    //          valid   rd     data           iv    ird    en    rs1   en    rs2   en   | ready  stl   en    rd     data           busy
    vecs[0]  = mk(3'b000, 5'd0, 32'h0,        1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 32'h0,        32'h0000_0008);
    vecs[1]  = mk(3'b001, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'b001, 1'b0, 1'b1, 5'd3, 32'hDEADBEEF, 32'h0000_0008);
    vecs[2]  = mk(3'b000, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'b000, 1'b0, 1'b0, 5'd3, 32'hDEADBEEF, 32'h0000_0000);
    vecs[3]  = mk(3'b010, 5'd0, 32'h1234,     1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'b010, 1'b0, 1'b0, 5'd0, 32'h1234,     32'h0000_0000);
    vecs[4]  = mk(3'b000, 5'd0, 32'h0,        1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 32'h1234,     32'h0000_0080);
    vecs[5]  = mk(3'b100, 5'd7, 32'h77,       1'b1, 5'd8, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 3'b100, 1'b1, 1'b1, 5'd7, 32'h77,       32'h0000_0080);
    vecs[6]  = mk(3'b000, 5'd0, 32'h0,        1'b1, 5'd8, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 3'b000, 1'b1, 1'b0, 5'd7, 32'h77,       32'h0000_0000);
    vecs[7]  = mk(3'b000, 5'd0, 32'h0,        1'b1, 5'd8, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 3'b000, 1'b0, 1'b0, 5'd7, 32'h77,       32'h0000_0100);
    vecs[8]  = mk(3'b001, 5'd9, 32'h99,       1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'b001, 1'b0, 1'b1, 5'd9, 32'h99,       32'h0000_0100);
    vecs[9]  = mk(3'b000, 5'd0, 32'h0,        1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'b000, 1'b0, 1'b0, 5'd9, 32'h99,       32'h0000_0300);
    vecs[10] = mk(3'b000, 5'd0, 32'h0,        1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'b000, 1'b1, 1'b0, 5'd9, 32'h99,       32'h0000_0300);
    vecs[11] = mk(3'b000, 5'd0, 32'h0,        1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 3'b000, 1'b1, 1'b0, 5'd9, 32'h99,       32'h0000_0300);
    vecs[12] = mk(3'b000, 5'd0, 32'h0,        1'b1, 5'd8, 1'b0, 5'd8, 1'b0, 5'd9, 1'b0, 3'b000, 1'b0, 1'b0, 5'd9, 32'h99,       32'h0000_0300);

    // Reset state
    step();
    step();
    chk("reset_rf_rd_en", {31'd0, bus.rf_rd_en}, 32'd0);
    chk("reset_rf_rd", {27'd0, bus.rf_rd}, 32'd0);
    chk("reset_rf_data", bus.rf_data_in, 32'd0);
    chk("reset_busy", bus.busy_vec, 32'd0);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 13; i++) begin
      bus.req_valid    = vecs[i].valid;
      bus.req_rd       = {3{vecs[i].rd}};
      bus.req_data     = {3{vecs[i].data}};
      bus.issue_valid  = vecs[i].iv;
      bus.issue_rd     = vecs[i].ird;
      bus.issue_rd_en  = vecs[i].ird_en;
      bus.issue_rs1    = vecs[i].rs1;
      bus.issue_rs1_en = vecs[i].rs1_en;
      bus.issue_rs2    = vecs[i].rs2;
      bus.issue_rs2_en = vecs[i].rs2_en;
      #1;
      chk($sformatf("v%0d_ready", i), {29'd0, bus.req_ready}, {29'd0, vecs[i].exp_ready});
      chk($sformatf("v%0d_stall", i), {31'd0, bus.issue_stall}, {31'd0, vecs[i].exp_stall});
      step();
      chk($sformatf("v%0d_rf_rd_en", i), {31'd0, bus.rf_rd_en}, {31'd0, vecs[i].exp_en});
      chk($sformatf("v%0d_rf_rd", i), {27'd0, bus.rf_rd}, {27'd0, vecs[i].exp_rd});
      chk($sformatf("v%0d_rf_data", i), bus.rf_data_in, vecs[i].exp_data);
      chk($sformatf("v%0d_busy", i), bus.busy_vec, vecs[i].exp_busy);
    end
    idle_inputs();

    // Reset asserted right after a grant of rd=5 (busy bits 8,9 still set)
    bus.req_valid = 3'b010;
    bus.req_rd    = {3{5'd5}};
    bus.req_data  = {3{32'h55}};
    #1;
    chk("rst_mid_ready", {29'd0, bus.req_ready}, 32'd2);
    step();
    chk("rst_mid_pre_en", {31'd0, bus.rf_rd_en}, 32'd1);
    chk("rst_mid_pre_rd", {27'd0, bus.rf_rd}, 32'd5);
    #2;
    rst_n = 1'b0;
    bus.req_valid = 3'b000;
    #1;
    chk("rst_mid_en", {31'd0, bus.rf_rd_en}, 32'd0);
    chk("rst_mid_rd", {27'd0, bus.rf_rd}, 32'd0);
    chk("rst_mid_busy", bus.busy_vec, 32'd0);
    step();
    chk("rst_hold_en", {31'd0, bus.rf_rd_en}, 32'd0);
    rst_n = 1'b1;

    // Arbitration order with all three requesters valid (pointer back at 0)
    bus.req_valid = 3'b111;
    bus.req_rd    = {5'd12, 5'd11, 5'd10};
    bus.req_data  = {32'hA2, 32'hA1, 32'hA0};
    for (int c = 0; c < 6; c++) begin
`ifdef WB_FIXED_PRIO_EN
      exp_idx = 0;
`else
      exp_idx = c % 3;
`endif
      #1;
      chk($sformatf("arb%0d_ready", c), {29'd0, bus.req_ready}, 32'd1 << exp_idx);
      step();
      chk($sformatf("arb%0d_rf_rd", c), {27'd0, bus.rf_rd}, 32'd10 + 32'(exp_idx));
      chk($sformatf("arb%0d_rf_data", c), bus.rf_data_in, 32'hA0 + 32'(exp_idx));
      chk($sformatf("arb%0d_rf_en", c), {31'd0, bus.rf_rd_en}, 32'd1);
    end
    idle_inputs();
    step();
    step();
    chk("final_rf_en", {31'd0, bus.rf_rd_en}, 32'd0);
    chk("final_busy", bus.busy_vec, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_wb_sched.md
Name: regfile_wb_sched

Overview:
- Write-back scheduler and scoreboard for the 32x32 integer register file. x0 is hardwired zero; the file has one write port (rd, rd_en, data_in) and two gated combinational read ports.
- Arbitrates NUM_REQ write-back requesters (ALU, load unit, CSR/mul) onto the single write port.
- Tracks a busy bit per architectural register, so decode stalls on RAW/WAW hazards until the write commits.
- Sits between execute/memory stages and the register file; its issue side faces decode.

Parameters:
- NUM_REQ, 3, number of write-back requesters (2..8)
- XLEN, 32, data width
- REG_ADDR_W, 5, register index width

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- req_valid  in  NUM_REQ  requester i has a write-back pending
- req_rd  in  NUM_REQ*REG_ADDR_W  packed destination index; slice i belongs to requester i
- req_data  in  NUM_REQ*XLEN  packed write data; slice i belongs to requester i
- req_ready  out  NUM_REQ  one-hot grant, combinational, same cycle
- issue_valid  in  1  decode presents an instruction
- issue_rd  in  REG_ADDR_W  destination to reserve
- issue_rd_en  in  1  instruction writes rd
- issue_rs1, issue_rs2  in  REG_ADDR_W  sources
- issue_rs1_en, issue_rs2_en  in  1  source used
- issue_stall  out  1  hazard; decode must hold
- rf_rd  out  REG_ADDR_W  to register file rd, registered
- rf_rd_en  out  1  to register file rd_en, registered
- rf_data_in  out  XLEN  to register file data_in, registered
- busy_vec  out  32  scoreboard bits; bit 0 always 0

Behaviour:
- Reset (reset low, asynchronous):
  - rf_rd=0, rf_rd_en=0, rf_data_in=0.
  - busy_vec=0; the round-robin pointer is 0.
  - Any write latched for commit is discarded.
- Arbitration:
  - A handshake occurs when req_valid[i] & req_ready[i].
  - At most one grant per cycle.
  - Search is round-robin starting at the pointer. The pointer moves to (granted index + 1) mod NUM_REQ, and only on a grant.
  - A requester holds valid, rd and data stable until ready; dropping valid without a grant is illegal.
- Write-port latency: one cycle.
  - On the grant edge, rf_rd and rf_data_in are loaded from the winner.
  - rf_rd_en = 1 if the winner's rd != 0, otherwise 0. A write to x0 is accepted and silently dropped.
  - With no grant, rf_rd_en = 0 and rf_rd/rf_data_in hold their values.
  - The register file captures data on the edge after the grant edge (the commit edge).
- Scoreboard:
  - set: on the edge where issue_valid & ~issue_stall & issue_rd_en & issue_rd != 0, busy[issue_rd] is set.
  - clear: on the commit edge (rf_rd_en=1), busy[rf_rd] is cleared. This happens whether or not the bit was set.
  - simultaneous set and clear of the same index: set wins, because the new instruction owns the register.
  - busy[0] is never set.
- Hazard, combinational:
  - issue_stall = issue_valid & ((rs1_en & busy[rs1]) | (rs2_en & busy[rs2]) | (rd_en & busy[rd])).
  - There is no bypass. The cycle after the commit edge, the busy bit is clear and the read port returns the new value.
- Back-to-back grants: a grant every cycle is allowed. The commit pipeline is one deep and never backpressures.

Optional Feature:
- WB_FIXED_PRIO_EN defined:
  - Fixed priority; the lowest index wins.
  - No pointer register.
  - Requester 0 (ALU) is never delayed.
- WB_FIXED_PRIO_EN undefined: round-robin as described under Behaviour.
- Scoreboard and commit timing are identical in both builds.

Decomposition:
- Package regfile_pkg:
  - constants XLEN=32, REG_ADDR_W=5, NUM_REGS=32, REG_ZERO=5'd0
  - typedef reg_idx_t [REG_ADDR_W-1:0]
  - typedef xword_t [XLEN-1:0]
- Sub-module wb_rr_arbiter:
  - parameter NUM_REQ; inputs req vector, clk, reset; outputs one-hot grant and grant index.
  - Holds the pointer; compiled as fixed priority when WB_FIXED_PRIO_EN is defined.
- The scoreboard and commit register live in the top module.

Test Plan:
- Reset: assert reset mid-write (grant of rd=5 just issued) -> rf_rd_en=0 immediately, busy_vec=0, x5 not written, pointer=0.
- Single write: issue rd=3 -> busy_vec[3]=1. Then req0 rd=3 data=32'hDEADBEEF -> ready0 the same cycle, rf_rd_en=1/rf_rd=3 the next cycle, busy_vec[3]=0 after the commit edge.
- Round-robin: all three valid for 6 cycles -> grants 0,1,2,0,1,2. With WB_FIXED_PRIO_EN -> 0 every cycle.
- RAW stall: x7 busy, issue rs1=7 -> issue_stall=1 until the commit edge of x7, then 0. No reservation is made while stalled.
- Set/clear collision: commit of x9 on the same edge as a new issue rd=9 -> busy_vec[9]=1 afterwards.
- x0: req rd=0 data=32'h1234 -> ready=1, rf_rd_en stays 0. Issue rd=0 -> busy_vec stays 0, no stall.
